// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: func3 encodings, FSM states,
// error codes and the request classifier used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    // Access size comes from func3[1:0] even for illegal codes, so misalignment
    // is judged first and wins over an illegal width.
    function automatic logic [1:0] lsu_classify(input logic we, input logic [2:0] func3,
                                                input logic [2:0] addr_lo, input logic wide);
        logic legal;
        logic misaligned;
        legal      = 1'b0;
        misaligned = 1'b0;
        case (func3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !we;
            F3_D:             legal = wide;
            F3_WU:            legal = wide && !we;
            default:          legal = 1'b0;
        endcase
        case (func3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo[1:0];
            2'b11:   misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
        if (misaligned) return ERR_MISALIGN;
        if (!legal)     return ERR_ILLEGAL;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Request, response and data-bus signals of the load/store unit. The master modport is
// the unit itself; the slave modport is the core plus memory environment around it.
interface rv_lsu_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_func3;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [4:0]            req_rd;
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W/8-1:0]   bus_be;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_ack;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  rsp_valid;
    logic                  rsp_rf_we;
    logic [4:0]            rsp_rd;
    logic [DATA_W-1:0]     rsp_data;
    logic [1:0]            rsp_err;
    logic                  busy;

    modport master (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, req_rd, bus_ack, bus_rdata,
        output req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output rsp_valid, rsp_rf_we, rsp_rd, rsp_data, rsp_err, busy
    );

    modport slave (
        output req_valid, req_we, req_func3, req_addr, req_wdata, req_rd, bus_ack, bus_rdata,
        input  req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  rsp_valid, rsp_rf_we, rsp_rd, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and store replication on the way out, lane
// extraction plus sign/zero extension on the way back.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]                  func3,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W/8-1:0]         be,
    output logic [DATA_W-1:0]           wdata_rep,
    output logic [DATA_W-1:0]           rdata_ext
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [DATA_W-1:0] lane;

    always_comb begin
        be        = '0;
        wdata_rep = wdata;
        rdata_ext = '0;
        lane      = rdata >> {offset, 3'b000};

        case (func3[1:0])
            2'b00: begin
                be        = BE_W'(8'h01) << offset;
                wdata_rep = {BE_W{wdata[7:0]}};
            end
            2'b01: begin
                be        = BE_W'(8'h03) << offset;
                wdata_rep = {(BE_W / 2){wdata[15:0]}};
            end
            2'b10: begin
                be        = BE_W'(8'h0F) << offset;
                wdata_rep = {(DATA_W / 32){wdata[31:0]}};
            end
            default: begin
                be        = BE_W'(8'hFF) << offset;
                wdata_rep = wdata;
            end
        endcase

        case (func3)
            F3_B:    rdata_ext = DATA_W'($signed(lane[7:0]));
            F3_BU:   rdata_ext = DATA_W'(lane[7:0]);
            F3_H:    rdata_ext = DATA_W'($signed(lane[15:0]));
            F3_HU:   rdata_ext = DATA_W'(lane[15:0]);
            F3_W:    rdata_ext = DATA_W'($signed(lane[31:0]));
            F3_WU:   rdata_ext = DATA_W'(lane[31:0]);
            default: rdata_ext = lane;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one Execute-stage request, runs it on a wait-state bus and
// returns an extended load result or an error code to Writeback.
module rv_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic      clk,
    input logic      rst,
    rv_lsu_if.master lsu
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic        WIDE  = (DATA_W == 64);

    lsu_state_t        state_q;
    logic              we_q;
    logic [2:0]        func3_q;
    logic [OFF_W-1:0]  off_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  wait_q;

    logic              in_access;
    logic              in_resp;
    logic              timed_out;
    logic              load_ok;
    logic [1:0]        req_err;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] rdata_ext;

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign req_err   = lsu_classify(lsu.req_we, lsu.req_func3, lsu.req_addr[2:0], WIDE);
    // wait_q counts completed ack-less cycles; the last allowed one is TIMEOUT-1.
    assign timed_out = (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            func3_q <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_NONE;
            wait_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (lsu.req_valid) begin
                        we_q    <= lsu.req_we;
                        func3_q <= lsu.req_func3;
                        off_q   <= lsu.req_addr[OFF_W-1:0];
                        rd_q    <= lsu.req_rd;
                        addr_q  <= {lsu.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        wdata_q <= lsu.req_wdata;
                        err_q   <= req_err;
                        wait_q  <= '0;
                        state_q <= (req_err == ERR_NONE) ? ACCESS : RESP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (lsu.bus_ack) begin
                        rdata_q <= lsu.bus_rdata;
                        state_q <= RESP;
                    end else if (timed_out) begin
                        err_q   <= ERR_TIMEOUT;
                        state_q <= RESP;
                    end else begin
                        wait_q  <= wait_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .func3     (func3_q),
        .offset    (off_q),
        .wdata     (wdata_q),
        .rdata     (rdata_q),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // Everything is decoded from the state register, so async reset clears it at once.
    assign load_ok       = in_resp && !we_q && (err_q == ERR_NONE);
    assign lsu.req_ready = (state_q == IDLE) || in_resp;
    assign lsu.busy      = (state_q != IDLE);
    assign lsu.bus_req   = in_access;
    assign lsu.bus_we    = in_access && we_q;
    assign lsu.bus_addr  = in_access ? addr_q : '0;
    assign lsu.bus_be    = in_access ? be : '0;
    assign lsu.bus_wdata = (in_access && we_q) ? wdata_rep : '0;
    assign lsu.rsp_valid = in_resp;
    assign lsu.rsp_rd    = in_resp ? rd_q : '0;
    assign lsu.rsp_err   = in_resp ? err_q : ERR_NONE;
    assign lsu.rsp_data  = load_ok ? rdata_ext : '0;
    assign lsu.rsp_rf_we = load_ok && (rd_q != 5'd0);

endmodule

// File: tb/tb_rv_lsu.sv
// Self-checking bench for rv_lsu: directed vector table, hand-written multi-cycle
// sequences and randomized transactions against a byte-level reference model.
module tb_rv_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_lsu_if #(.DATA_W(32), .ADDR_W(32)) if32 ();
    rv_lsu_if #(.DATA_W(64), .ADDR_W(32)) if64 ();

    rv_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .lsu (if32)
    );

    rv_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .lsu (if64)
    );

    typedef struct {
        int          nreq;
        int          lat;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        bwe;
        logic [1:0]  err;
        logic [31:0] data;
        logic        rfwe;
        logic [4:0]  rd;
        logic        unstable;
        logic        extra;
        logic        hung;
    } obs_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          ack_wait;
        obs_t        exp;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference: sizes, lanes and extension computed with plain integer arithmetic.
    function automatic obs_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input logic [4:0] rd, input int ack_wait);
        obs_t e;
        int size, off;
        logic legal;
        logic [31:0] val, msk;
        e = '{default: 0};
        e.rd = rd;
        size = 1 << f3[1:0];
        off = int'(addr % 4);
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if ((addr % size) != 0) e.err = 2'd1;
        else if (!legal)        e.err = 2'd2;
        if (e.err != 2'd0) begin
            e.lat = 1;
            return e;
        end
        e.baddr = addr & ~32'h3;
        e.bwe = we;
        e.be = 4'(((1 << size) - 1) << off);
        if (we) for (int i = 0; i < 4; i++) e.bwdata[8*i +: 8] = 8'(wdata >> (8 * (i % size)));
        if (ack_wait < 0 || ack_wait >= 4) begin
            e.err = 2'd3;
            e.nreq = 4;
            e.lat = 5;
        end else begin
            e.nreq = ack_wait + 1;
            e.lat = ack_wait + 2;
            if (!we) begin
                msk = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
                val = (rdata >> (8 * off)) & msk;
                if (!f3[2] && val[8*size-1]) val = val | ~msk;
                e.data = val;
                e.rfwe = (rd != 5'd0);
            end
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [4:0] rd, input int ack_wait, input logic [1:0] err,
                                input int lat, input int nreq, input logic [3:0] be,
                                input logic [31:0] baddr, input logic [31:0] bwdata,
                                input logic bwe, input logic [31:0] data, input logic rfwe);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rd = rd; v.ack_wait = ack_wait;
        v.exp = '{default: 0};
        v.exp.err = err; v.exp.lat = lat; v.exp.nreq = nreq; v.exp.be = be;
        v.exp.baddr = baddr; v.exp.bwdata = bwdata; v.exp.bwe = bwe;
        v.exp.data = data; v.exp.rfwe = rfwe; v.exp.rd = rd;
        return v;
    endfunction

    // Starts at a negedge with the unit idle; ends at a negedge with it idle again.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic [4:0] rd, input int ack_wait, output obs_t o);
        int cyc;
        o = '{default: 0};
        if32.req_valid = 1'b1;
        if32.req_we = we;
        if32.req_func3 = f3;
        if32.req_addr = addr;
        if32.req_wdata = wdata;
        if32.req_rd = rd;
        @(posedge clk);
        @(negedge clk);
        if32.req_valid = 1'b0;
        cyc = 1;
        while (!if32.rsp_valid && cyc < 20) begin
            if (if32.bus_req) begin
                if (o.nreq == 0) begin
                    o.be = if32.bus_be;
                    o.baddr = if32.bus_addr;
                    o.bwdata = if32.bus_wdata;
                    o.bwe = if32.bus_we;
                end else if (o.be !== if32.bus_be || o.baddr !== if32.bus_addr ||
                             o.bwdata !== if32.bus_wdata || o.bwe !== if32.bus_we) begin
                    o.unstable = 1'b1;
                end
                if32.bus_ack = (o.nreq == ack_wait);
                if32.bus_rdata = (o.nreq == ack_wait) ? rdata : $urandom();
                o.nreq++;
            end
            @(posedge clk);
            @(negedge clk);
            if32.bus_ack = 1'b0;
            cyc++;
        end
        o.hung = !if32.rsp_valid;
        o.lat = cyc;
        o.err = if32.rsp_err;
        o.data = if32.rsp_data;
        o.rfwe = if32.rsp_rf_we;
        o.rd = if32.rsp_rd;
        @(posedge clk);
        @(negedge clk);
        o.extra = if32.rsp_valid || if32.busy;
    endtask

    task automatic cmp_obs(input string tag, input obs_t o, input obs_t e);
        chk({tag, ".hung"}, 64'(o.hung), 64'(0));
        chk({tag, ".lat"}, 64'(o.lat), 64'(e.lat));
        chk({tag, ".nreq"}, 64'(o.nreq), 64'(e.nreq));
        chk({tag, ".bus_be"}, 64'(o.be), 64'(e.be));
        chk({tag, ".bus_addr"}, 64'(o.baddr), 64'(e.baddr));
        chk({tag, ".bus_wdata"}, 64'(o.bwdata), 64'(e.bwdata));
        chk({tag, ".bus_we"}, 64'(o.bwe), 64'(e.bwe));
        chk({tag, ".err"}, 64'(o.err), 64'(e.err));
        chk({tag, ".data"}, 64'(o.data), 64'(e.data));
        chk({tag, ".rf_we"}, 64'(o.rfwe), 64'(e.rfwe));
        chk({tag, ".rd"}, 64'(o.rd), 64'(e.rd));
        chk({tag, ".stable"}, 64'(o.unstable), 64'(0));
        chk({tag, ".one_pulse"}, 64'(o.extra), 64'(0));
    endtask

    task automatic run64(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] rdata,
                         output logic [63:0] data, output logic [7:0] be, output int lat);
        be = '0;
        if64.req_valid = 1'b1;
        if64.req_we = 1'b0;
        if64.req_func3 = f3;
        if64.req_addr = addr;
        if64.req_rd = 5'd9;
        @(posedge clk);
        @(negedge clk);
        if64.req_valid = 1'b0;
        lat = 1;
        while (!if64.rsp_valid && lat < 10) begin
            if (if64.bus_req) begin
                be = if64.bus_be;
                if64.bus_ack = 1'b1;
                if64.bus_rdata = rdata;
            end
            @(posedge clk);
            @(negedge clk);
            if64.bus_ack = 1'b0;
            lat++;
        end
        data = if64.rsp_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        obs_t o, e;
        logic seen;
        logic [63:0] d64;
        logic [7:0] be64;
        int lat64;

        {if32.req_valid, if32.req_we, if32.req_func3, if32.req_addr, if32.req_wdata,
         if32.req_rd, if32.bus_ack, if32.bus_rdata} = '0;
        {if64.req_valid, if64.req_we, if64.req_func3, if64.req_addr, if64.req_wdata,
         if64.req_rd, if64.bus_ack, if64.bus_rdata} = '0;

        vecs[0]  = mk(0, 3'd0, 32'h1003, 0, 32'h80FF_1234, 1, 0,
                      0, 2, 1, 4'h8, 32'h1000, 0, 0, 32'hFFFF_FF80, 1);
        vecs[1]  = mk(0, 3'd4, 32'h1003, 0, 32'h80FF_1234, 1, 0,
                      0, 2, 1, 4'h8, 32'h1000, 0, 0, 32'h0000_0080, 1);
        vecs[2]  = mk(1, 3'd1, 32'h2002, 32'hDEAD_BEEF, 0, 1, 3,
                      0, 5, 4, 4'hC, 32'h2000, 32'hBEEF_BEEF, 1, 0, 0);
        vecs[3]  = mk(0, 3'd2, 32'h3001, 0, 0, 1, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 3'd3, 32'h3000, 0, 0, 1, 0, 2, 1, 0, 4'h0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 3'd2, 32'h5000, 0, 32'h1234_5678, 1, -1,
                      3, 5, 4, 4'hF, 32'h5000, 0, 0, 0, 0);
        vecs[6]  = mk(0, 3'd2, 32'h5004, 0, 32'h1234_5678, 1, 3,
                      0, 5, 4, 4'hF, 32'h5004, 0, 0, 32'h1234_5678, 1);
        vecs[7]  = mk(0, 3'd2, 32'h5008, 0, 32'hCAFE_F00D, 0, 0,
                      0, 2, 1, 4'hF, 32'h5008, 0, 0, 32'hCAFE_F00D, 0);
        vecs[8]  = mk(0, 3'd1, 32'h6002, 0, 32'h8001_0000, 3, 1,
                      0, 3, 2, 4'hC, 32'h6000, 0, 0, 32'hFFFF_8001, 1);
        vecs[9]  = mk(0, 3'd5, 32'h6002, 0, 32'h8001_0000, 3, 0,
                      0, 2, 1, 4'hC, 32'h6000, 0, 0, 32'h0000_8001, 1);
        vecs[10] = mk(1, 3'd0, 32'h7001, 32'h0000_00AB, 0, 1, 0,
                      0, 2, 1, 4'h2, 32'h7000, 32'hABAB_ABAB, 1, 0, 0);
        vecs[11] = mk(1, 3'd2, 32'h7000, 32'h1122_3344, 0, 1, 2,
                      0, 4, 3, 4'hF, 32'h7000, 32'h1122_3344, 1, 0, 0);
        vecs[12] = mk(0, 3'd3, 32'h3001, 0, 0, 1, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 3'd4, 32'h7000, 0, 0, 1, 0, 2, 1, 0, 4'h0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 3'd6, 32'h7000, 0, 0, 1, 0, 2, 1, 0, 4'h0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset.req_ready", 64'(if32.req_ready), 64'(1));
        chk("reset.busy", 64'(if32.busy), 64'(0));
        chk("reset.bus_req", 64'(if32.bus_req), 64'(0));
        chk("reset.bus_be", 64'(if32.bus_be), 64'(0));
        chk("reset.rsp_valid", 64'(if32.rsp_valid), 64'(0));
        chk("reset.rsp_data", 64'(if32.rsp_data), 64'(0));
        chk("reset.rsp_err", 64'(if32.rsp_err), 64'(0));

        for (int i = 0; i < 15; i++) begin
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].rd, vecs[i].ack_wait, o);
            cmp_obs($sformatf("vec%0d", i), o, vecs[i].exp);
        end

        // Back-to-back: LW rd=5, then SW presented while the LW is still on the bus.
        if32.req_valid = 1'b1; if32.req_we = 1'b0; if32.req_func3 = 3'd2;
        if32.req_addr = 32'h100; if32.req_rd = 5'd5;
        @(posedge clk); @(negedge clk);
        chk("b2b.first_req", 64'(if32.bus_req), 64'(1));
        chk("b2b.ready_in_access", 64'(if32.req_ready), 64'(0));
        if32.req_we = 1'b1; if32.req_addr = 32'h104; if32.req_wdata = 32'h55AA_33CC;
        if32.req_rd = 5'd7;
        if32.bus_ack = 1'b1; if32.bus_rdata = 32'h0BAD_BEEF;
        @(posedge clk); @(negedge clk);
        if32.bus_ack = 1'b0;
        chk("b2b.rsp_valid", 64'(if32.rsp_valid), 64'(1));
        chk("b2b.rsp_rd", 64'(if32.rsp_rd), 64'(5));
        chk("b2b.rf_we", 64'(if32.rsp_rf_we), 64'(1));
        chk("b2b.rsp_data", 64'(if32.rsp_data), 64'h0BAD_BEEF);
        chk("b2b.ready_in_resp", 64'(if32.req_ready), 64'(1));
        @(posedge clk); @(negedge clk);
        if32.req_valid = 1'b0;
        chk("b2b.second_req", 64'(if32.bus_req), 64'(1));
        chk("b2b.second_we", 64'(if32.bus_we), 64'(1));
        chk("b2b.second_addr", 64'(if32.bus_addr), 64'h104);
        chk("b2b.second_wdata", 64'(if32.bus_wdata), 64'h55AA_33CC);
        if32.bus_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        if32.bus_ack = 1'b0;
        chk("b2b.store_rsp", 64'(if32.rsp_valid), 64'(1));
        chk("b2b.store_rf_we", 64'(if32.rsp_rf_we), 64'(0));
        chk("b2b.store_data", 64'(if32.rsp_data), 64'(0));
        @(posedge clk); @(negedge clk);
        chk("b2b.idle", 64'(if32.busy), 64'(0));

        // Stray ack while idle must not start or complete anything.
        if32.bus_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        if32.bus_ack = 1'b0;
        chk("stray_ack.rsp_valid", 64'(if32.rsp_valid), 64'(0));
        chk("stray_ack.busy", 64'(if32.busy), 64'(0));

        // Reset in the middle of an access abandons it without a response.
        if32.req_valid = 1'b1; if32.req_we = 1'b0; if32.req_func3 = 3'd2;
        if32.req_addr = 32'h200; if32.req_rd = 5'd4;
        @(posedge clk); @(negedge clk);
        if32.req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_mid.in_access", 64'(if32.bus_req), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_mid.bus_req", 64'(if32.bus_req), 64'(0));
        chk("rst_mid.busy", 64'(if32.busy), 64'(0));
        chk("rst_mid.rsp_valid", 64'(if32.rsp_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.req_ready", 64'(if32.req_ready), 64'(1));
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            seen = seen | if32.rsp_valid | if32.bus_req;
        end
        chk("rst_mid.no_activity", 64'(seen), 64'(0));

        // 64-bit datapath.
        run64(3'd6, 32'h4, 64'hFFFF_FFFF_0000_0000, d64, be64, lat64);
        chk("w64.lwu_data", d64, 64'h0000_0000_FFFF_FFFF);
        chk("w64.lwu_be", 64'(be64), 64'hF0);
        chk("w64.lwu_lat", 64'(lat64), 64'(2));
        run64(3'd2, 32'h4, 64'hFFFF_FFFF_0000_0000, d64, be64, lat64);
        chk("w64.lw_data", d64, 64'hFFFF_FFFF_FFFF_FFFF);
        run64(3'd3, 32'h8, 64'h0123_4567_89AB_CDEF, d64, be64, lat64);
        chk("w64.ld_data", d64, 64'h0123_4567_89AB_CDEF);
        chk("w64.ld_be", 64'(be64), 64'hFF);
        run64(3'd3, 32'hC, 64'h0, d64, be64, lat64);
        chk("w64.ld_misalign_lat", 64'(lat64), 64'(1));

        for (int i = 0; i < 60; i++) begin
            logic we_r;
            logic [2:0] f3_r;
            logic [31:0] a_r, wd_r, rdat_r;
            logic [4:0] rd_r;
            int aw_r;
            we_r = 1'($urandom_range(0, 1));
            f3_r = 3'($urandom_range(0, 7));
            a_r = $urandom();
            wd_r = $urandom();
            rdat_r = $urandom();
            rd_r = 5'($urandom_range(0, 31));
            aw_r = $urandom_range(0, 5);
            e = model(we_r, f3_r, a_r, wd_r, rdat_r, rd_r, aw_r);
            run_txn(we_r, f3_r, a_r, wd_r, rdat_r, rd_r, aw_r, o);
            cmp_obs($sformatf("rnd%0d", i), o, e);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
